// File: rtl/event_injector.sv
// event_injector: buffers timestamped events and emits each on stage 0 of the LLC frame.
// Optional: define EVENT_INJECTOR_FRAME_CNT_EN to add the frame_cnt output.
module event_injector #(
    parameter int DATA_W  = 64,
    parameter int DELTA_W = 32,
    parameter int DEPTH   = 8,
    parameter int PHASES  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DELTA_W-1:0]         wr_delta,
    output logic [DATA_W-1:0]          input_a,
    output logic                       new_input,
    output logic [$clog2(PHASES)-1:0]  stage,
    output logic                       busy
`ifdef EVENT_INJECTOR_FRAME_CNT_EN
    ,
    output logic [31:0]                frame_cnt
`endif
);

    localparam int SW = $clog2(PHASES);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0]  mem_data  [DEPTH];
    logic [DELTA_W-1:0] mem_delta [DEPTH];
    logic [AW-1:0]      wptr, rptr;
    logic [CW-1:0]      count, count_next;

    logic [DATA_W-1:0]  data_q;
    logic [DELTA_W-1:0] cnt_q;

    logic push, pop, emit, dec;
    logic empty, frame_b;

    assign push       = wr_valid && wr_ready;
    assign empty      = (count == '0);
    assign frame_b    = en && (stage == SW'(PHASES - 1));
    assign count_next = count + CW'(push) - CW'(pop);
    assign busy       = !empty || (state_q != IDLE);

    // Stage counter: free-running LLC phase, frozen while disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage <= '0;
        end else if (en) begin
            stage <= stage + SW'(1);
        end
    end

    // FIFO storage has no reset; only pointers and count are cleared
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr]  <= wr_data;
            mem_delta[wptr] <= wr_delta;
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            wr_ready <= 1'b1;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count    <= count_next;
            wr_ready <= (count_next != CW'(DEPTH));
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave WAIT only when the slot fires with nothing queued
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (en && !empty) state_d = WAIT;
            WAIT: if (frame_b && cnt_q == '0 && empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: pop, emit and countdown strobes
    always_comb begin
        pop  = 1'b0;
        emit = 1'b0;
        dec  = 1'b0;
        unique case (state_q)
            IDLE: pop = en && !empty;
            WAIT: begin
                if (frame_b) begin
                    if (cnt_q == '0) begin
                        emit = 1'b1;
                        pop  = !empty;
                    end else begin
                        dec = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Current event: load on pop, count frames down otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (pop) begin
            data_q <= mem_data[rptr];
            cnt_q  <= mem_delta[rptr];
        end else if (dec) begin
            cnt_q <= cnt_q - DELTA_W'(1);
        end
    end

    // Monitor port: one-cycle pulse, value held between emissions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            new_input <= 1'b0;
            input_a   <= '0;
        end else begin
            new_input <= emit;
            if (emit) input_a <= data_q;
        end
    end

`ifdef EVENT_INJECTOR_FRAME_CNT_EN
    // Frame counter for timestamping emissions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if (frame_b) begin
            frame_cnt <= frame_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_event_injector.sv
// tb_event_injector: directed tests with a frame-schedule reference model.
// Builds with or without EVENT_INJECTOR_FRAME_CNT_EN.
module tb_event_injector;

    localparam int DATA_W  = 64;
    localparam int DELTA_W = 32;
    localparam int DEPTH   = 8;
    localparam int PHASES  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data = '0;
    logic [DELTA_W-1:0] wr_delta = '0;
    logic [DATA_W-1:0] input_a;
    logic              new_input;
    logic [1:0]        stage;
    logic              busy;
`ifdef EVENT_INJECTOR_FRAME_CNT_EN
    logic [31:0]       frame_cnt;
`endif

    event_injector #(
        .DATA_W (DATA_W),
        .DELTA_W(DELTA_W),
        .DEPTH  (DEPTH),
        .PHASES (PHASES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_delta (wr_delta),
        .input_a  (input_a),
        .new_input(new_input),
        .stage    (stage),
        .busy     (busy)
`ifdef EVENT_INJECTOR_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int c0 = 0;
    bit live = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc - c0);
        end
    endtask

    // Reference model: events carry an absolute due frame number
    typedef struct {
        longint v;
        longint d;
    } ev_t;

    ev_t    mq[$];
    ev_t    e;
    bit     m_loaded;
    longint m_due;
    longint m_cur;
    longint fbc;
    int     m_stage;
    bit     exp_new;
    longint exp_a;
    bit     b, psh;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mq.delete();
                m_loaded = 1'b0;
                m_due    = 0;
                m_cur    = 0;
                fbc      = 0;
                m_stage  = 0;
                exp_new  = 1'b0;
                exp_a    = 0;
            end else begin
                b   = en && (m_stage == PHASES - 1);
                psh = wr_valid && (mq.size() < DEPTH);
                exp_new = 1'b0;
                if (en) begin
                    if (m_loaded && b && fbc == m_due) begin
                        exp_new  = 1'b1;
                        exp_a    = m_cur;
                        m_loaded = 1'b0;
                    end
                    if (!m_loaded && mq.size() > 0) begin
                        e        = mq.pop_front();
                        m_cur    = e.v;
                        m_due    = fbc + (b ? 1 : 0) + e.d;
                        m_loaded = 1'b1;
                    end
                end
                if (b) fbc++;
                if (en) m_stage = (m_stage + 1) % PHASES;
                if (psh) begin
                    e.v = longint'(wr_data);
                    e.d = longint'(wr_delta);
                    mq.push_back(e);
                end
            end
        end
    end

    int     plog_c[$];
    longint plog_v[$];

    // Per-cycle comparison against the model, plus pulse logging
    initial begin
        forever begin
            @(negedge clk);
            if (rst && live) begin
                check("new_input", new_input, exp_new);
                check("input_a", input_a, exp_a);
                check("stage", stage, m_stage);
                check("wr_ready", wr_ready, (mq.size() < DEPTH) ? 1 : 0);
                check("busy", busy, (m_loaded || mq.size() > 0) ? 1 : 0);
`ifdef EVENT_INJECTOR_FRAME_CNT_EN
                check("frame_cnt", frame_cnt, fbc & 64'hFFFF_FFFF);
`endif
                if (new_input) begin
                    check("pulse_stage", stage, 0);
                    plog_c.push_back(cyc - c0);
                    plog_v.push_back(longint'(input_a));
                end
            end
        end
    end

    task automatic goto(input int k);
        while (cyc - c0 < k) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_input_a", input_a, 0);
        check("rst_new_input", new_input, 0);
        check("rst_stage", stage, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_ready", wr_ready, 1);
`ifdef EVENT_INJECTOR_FRAME_CNT_EN
        check("rst_frame_cnt", frame_cnt, 0);
`endif
        plog_c.delete();
        plog_v.delete();
        rst  = 1'b1;
        live = 1'b1;
        c0   = cyc;
    endtask

    task automatic drive(input longint v, input longint d);
        wr_valid = 1'b1;
        wr_data  = DATA_W'(v);
        wr_delta = DELTA_W'(d);
    endtask

    initial begin
        // Reset, then a single delta-0 event
        en = 1'b1;
        do_reset();
        drive(5, 0);
        goto(1);
        wr_valid = 1'b0;
        goto(30);
        check("t2_pulses", plog_c.size(), 1);
        if (plog_c.size() == 1) begin
            check("t2_cycle", plog_c[0], 4);
            check("t2_value", plog_v[0], 5);
        end
        check("t2_hold", input_a, 5);
        check("t2_busy", busy, 0);

        // Spacing: delta 2 then delta 0
        en = 1'b1;
        do_reset();
        drive(1, 2);
        goto(1);
        drive(2, 0);
        goto(2);
        wr_valid = 1'b0;
        goto(30);
        check("t3_pulses", plog_c.size(), 2);
        if (plog_c.size() == 2) begin
            check("t3_cycle0", plog_c[0], 12);
            check("t3_value0", plog_v[0], 1);
            check("t3_cycle1", plog_c[1], 16);
            check("t3_value1", plog_v[1], 2);
        end

        // Back-pressure with the schedule stalled
        en = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) goto(i);
            drive(10 + i, 0);
        end
        goto(8);
        drive(18, 0);
        check("t4_full", wr_ready, 0);
        goto(10);
        check("t4_held", wr_ready, 0);
        en = 1'b1;
        goto(11);
        check("t4_reopen", wr_ready, 1);
        goto(12);
        wr_valid = 1'b0;
        check("t4_refull", wr_ready, 0);
        goto(60);
        check("t4_pulses", plog_v.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < plog_v.size()) check("t4_order", plog_v[i], 10 + i);
        end
        check("t4_first", (plog_c.size() > 0) ? plog_c[0] : -1, 14);

        // Stall for 10 cycles while waiting with delta 1
        en = 1'b1;
        do_reset();
        drive(7, 1);
        goto(1);
        wr_valid = 1'b0;
        goto(4);
        en = 1'b0;
        goto(8);
        check("t5_frozen", stage, 0);
        goto(14);
        en = 1'b1;
        goto(30);
        check("t5_pulses", plog_c.size(), 1);
        if (plog_c.size() == 1) begin
            check("t5_cycle", plog_c[0], 18);
            check("t5_value", plog_v[0], 7);
        end

        // Reset while waiting with three more events queued
        en = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) goto(i);
            drive(21 + i, 5);
        end
        goto(4);
        wr_valid = 1'b0;
        goto(6);
        check("t6_busy_pre", busy, 1);
        do_reset();
        goto(40);
        check("t6_pulses", plog_c.size(), 0);
        check("t6_busy", busy, 0);
        check("t6_ready", wr_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/event_injector.md
# event_injector

Hardware input-stream source for the RTLola monitor. It buffers timestamped input events from a host or stimulus master and presents each event to the monitor's input port (`input_a`, `new_input`). Every event is aligned to stage 0 of the monitor's PHASES-cycle LLC schedule, so the monitor's "new data at stage 0" requirement holds. It sits directly in front of `topEntity` and is the driving end of the monitor input interface.

## Interface

Parameters:
- `DATA_W`, 64, event value width (signed).
- `DELTA_W`, 32, inter-event delay width, in frames.
- `DEPTH`, 8, event FIFO depth (power of two, ≥2).
- `PHASES`, 4, LLC cycles per HLC frame (power of two, ≥2).

Ports. One clock. Reset `rst` is asynchronous and active-low.
- `clk`, in, 1, system clock.
- `rst`, in, 1, asynchronous reset, active-low.
- `en`, in, 1, global enable; stalls the schedule when low.
- `wr_valid`, in, 1, an event is offered.
- `wr_ready`, out, 1, FIFO can accept; equals `!full`, registered.
- `wr_data`, in, DATA_W, event value.
- `wr_delta`, in, DELTA_W, number of whole frames to wait after the previous emission slot.
- `input_a`, out, DATA_W, value of the last emitted event (held).
- `new_input`, out, 1, one-cycle pulse coinciding with `stage == 0`.
- `stage`, out, log2(PHASES), current LLC phase.
- `busy`, out, 1, FIFO non-empty or state ≠ IDLE.

## Operation

- **Stage counter:**
  - Increments modulo PHASES on each `en` cycle.
  - A frame boundary is the cycle with `en && stage == PHASES-1`.
- **FIFO:**
  - Push when `wr_valid && wr_ready`.
  - The pushed entry is visible to the FSM on the next cycle.
  - `wr_ready` drops in the cycle after the push that fills the FIFO, and rises in the cycle after the pop that frees a slot.
  - No push occurs while full. Back-pressure only; nothing is dropped.
- **FSM states:**
  - **IDLE:** if the FIFO is non-empty, pop the head into `data_q`, set `cnt_q = delta`, and go to WAIT. The pop and the transition happen in the same cycle.
  - **WAIT:** on each frame boundary:
    - If `cnt_q != 0`, decrement `cnt_q`.
    - If `cnt_q == 0`, register `new_input <= 1` and `input_a <= data_q`. `stage` wraps to 0 on the same edge.
    - Then go to IDLE. If the FIFO is non-empty, instead pop the next entry and stay in WAIT with the new `data_q`/`cnt_q`.
- **Emission spacing:**
  - The emission slot is the frame boundary at which `cnt_q == 0` in WAIT.
  - Delta 0 emits on the first frame boundary after the entry is loaded.
  - Back-to-back delta-0 entries emit in consecutive frames, PHASES cycles apart.
- `new_input` is cleared on the next clock, so it is exactly one cycle wide.
- `input_a` holds its value between emissions.
- **`en` low:**
  - `stage`, `cnt_q` and the FSM freeze.
  - `new_input` is 0 on the next clock.
  - FIFO pushes are still accepted.
- **Reset:**
  - Clears the FIFO, the FSM (IDLE), `cnt_q`, `data_q` and `stage`.
  - An event pending in WAIT is discarded without a pulse.

## Timing

- **Reset values:**
  - `input_a = 0`, `new_input = 0`, `stage = 0`, `busy = 0`.
  - `wr_ready = 1` (driven 1 once out of reset).
- **Latency into an empty, idle block** (push accepted at edge t, `en` high):
  - Entry loaded at edge t+1.
  - Pulse in the first cycle with `stage == 0` after the load, plus `delta*PHASES` cycles.
- **Arithmetic:** `cnt_q` is a DELTA_W-bit down-counter and never wraps below 0. `stage` is a modulo-PHASES wrap.
- **Push and pop in the same cycle while the FIFO is full:** impossible, because `wr_ready = 0`.
- **Push and pop in the same cycle while the FIFO is partially full:** both take effect and the count is unchanged.

## Configuration

- Macro `EVENT_INJECTOR_FRAME_CNT_EN`.
- **Defined:** adds output `frame_cnt` [31:0].
  - Reset value 0.
  - Increments at every frame boundary and wraps at 2^32.
  - Lets the bench timestamp emissions.
- **Undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan

1. **Reset:** hold `rst` = 0 for 3 cycles → `input_a = 0`, `new_input = 0`, `stage = 0`, `busy = 0`. After release `wr_ready = 1`.
2. **Single event:** `en` = 1, push (5, delta 0) → exactly one `new_input` pulse with `stage == 0` and `input_a = 5`. `input_a` stays 5 and `busy` returns to 0.
3. **Spacing:** push (1, 2) then (2, 0) → the first pulse comes 2 frames (8 cycles) after the first eligible stage 0. The second pulse follows exactly 4 cycles later with `input_a = 2`.
4. **Back-pressure:** `en` = 0, push 8 entries → `wr_ready` = 0 after the 8th, and a 9th `wr_valid` is held. Raise `en` → the 9th is accepted one cycle after the first pop. All 9 values emit in push order.
5. **Stall:** drop `en` for 10 cycles while in WAIT with delta 1 → `stage` is frozen, and the pulse is delayed by exactly 10 cycles versus an unstalled run.
6. **Reset mid-operation:** assert `rst` while in WAIT with 3 queued events → no pulse, FIFO empty, `busy` = 0 after release. With `EVENT_INJECTOR_FRAME_CNT_EN` defined, `frame_cnt` reads 0.
